// File: rtl/audio_pkg.sv
// Shared constants for the I2S audio transmitter.
// Frame geometry, divider tap positions and I2S slot bounds.
package audio_pkg;

  localparam int AUDIO_DATA_W = 16;
  localparam int FRAME_CNT_W  = 10;

  localparam int MSB_SLOT = 1;
  localparam int LSB_SLOT = 16;

  localparam int MCLK_BIT = 1;
  localparam int SCK_BIT  = 3;
  localparam int LRCK_BIT = 9;

  // slot index k = cnt[LRCK_BIT-1:SCK_BIT+1]
  localparam int SLOT_LO = SCK_BIT + 1;
  localparam int SLOT_W  = LRCK_BIT - SLOT_LO;

endpackage

// File: rtl/i2s_audio_tx_if.sv
// Sample/control inputs and Pmod I2S2 pin outputs.
// master: sample source; slave: transmitter.
interface i2s_audio_tx_if #(
  parameter int DATA_W = audio_pkg::AUDIO_DATA_W
);

  logic              en;
  logic [DATA_W-1:0] sample_l;
  logic [DATA_W-1:0] sample_r;
  logic [2:0]        volume;
  logic              mute;

  logic audio_mclk;
  logic audio_lrck;
  logic audio_sck;
  logic audio_sdin;
  logic frame_start;

  modport master (
    output en, sample_l, sample_r,
    output volume, mute,
    input  audio_mclk, audio_lrck,
    input  audio_sck, audio_sdin,
    input  frame_start
  );

  modport slave (
    input  en, sample_l, sample_r,
    input  volume, mute,
    output audio_mclk, audio_lrck,
    output audio_sck, audio_sdin,
    output frame_start
  );

endinterface

// File: rtl/audio_vol_scale.sv
// Mute and shift-based volume stage (combinational, signed).
// sample/volume/mute in, proc out.
module audio_vol_scale
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [2:0]        volume,
  input  logic                     mute,
  output logic signed [DATA_W-1:0] proc
);

  always_comb begin
    proc = '0;
    if (!mute) begin
      proc = sample >>> volume;
    end
  end

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S transmitter: frame counter, capture regs, serialiser.
// clk/rst plain; samples, controls and DAC pins on bus.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int CNT_W  = FRAME_CNT_W,
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic           clk,
  input  logic           rst,
  i2s_audio_tx_if.slave  bus
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [DATA_W-1:0] hold_l_q, hold_l_d;
  logic signed [DATA_W-1:0] hold_r_q, hold_r_d;
  logic signed [DATA_W-1:0] proc_l, proc_r;

  logic mclk_q, mclk_d;
  logic sck_q, sck_d;
  logic lrck_q, lrck_d;
  logic sdin_q, sdin_d;
  logic fs_q, fs_d;

  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] bit_idx;
  logic [DATA_W-1:0] word;

  audio_vol_scale #(.DATA_W(DATA_W)) u_scale_l (
    .sample (bus.sample_l),
    .volume (bus.volume),
    .mute   (bus.mute),
    .proc   (proc_l)
  );

  audio_vol_scale #(.DATA_W(DATA_W)) u_scale_r (
    .sample (bus.sample_r),
    .volume (bus.volume),
    .mute   (bus.mute),
    .proc   (proc_r)
  );

  always_comb begin
    cnt_d    = '0;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    mclk_d   = 1'b0;
    sck_d    = 1'b0;
    lrck_d   = 1'b0;
    sdin_d   = 1'b0;
    fs_d     = 1'b0;

    slot    = cnt_q[LRCK_BIT-1:SLOT_LO];
    bit_idx = SLOT_W'(LSB_SLOT) - slot;
    word    = cnt_q[LRCK_BIT] ? hold_r_q
                              : hold_l_q;

    if (bus.en) begin
      cnt_d  = cnt_q + CNT_W'(1);
      mclk_d = cnt_q[MCLK_BIT];
      sck_d  = cnt_q[SCK_BIT];
      lrck_d = cnt_q[LRCK_BIT];
      fs_d   = (cnt_q == '0);

      // slot only moves on cnt[3:0] wrap, so sdin
      // follows the SCLK falling edge
      if (slot >= SLOT_W'(MSB_SLOT) &&
          slot <= SLOT_W'(LSB_SLOT)) begin
        sdin_d = word[bit_idx[IDX_W-1:0]];
      end

      if (cnt_q == CNT_LAST) begin
        hold_l_d = proc_l;
        hold_r_d = proc_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      mclk_q   <= 1'b0;
      sck_q    <= 1'b0;
      lrck_q   <= 1'b0;
      sdin_q   <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      mclk_q   <= mclk_d;
      sck_q    <= sck_d;
      lrck_q   <= lrck_d;
      sdin_q   <= sdin_d;
      fs_q     <= fs_d;
    end
  end

  assign bus.audio_mclk  = mclk_q;
  assign bus.audio_sck   = sck_q;
  assign bus.audio_lrck  = lrck_q;
  assign bus.audio_sdin  = sdin_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx.
// Checks every cycle's pins and each frame's serial words.
module tb_i2s_audio_tx;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  i2s_audio_tx_if bus ();

  i2s_audio_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int bc = 0;
  logic [15:0] hl = '0, hr = '0;
  logic [15:0] nl = '0, nr = '0;
  logic [15:0] rx_l = '0, rx_r = '0;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic step();
    logic s_rst, s_en, e_sd;
    logic [9:0] p;
    logic [4:0] k;
    logic [15:0] w;
    s_rst = rst;
    s_en  = bus.en;
    @(posedge clk);
    #1;
    if (s_rst || !s_en) begin
      if (s_rst) begin
        hl = '0;
        hr = '0;
      end
      bc = 0;
      chk("idle_mclk", 16'(bus.audio_mclk), 16'h0);
      chk("idle_sck", 16'(bus.audio_sck), 16'h0);
      chk("idle_lrck", 16'(bus.audio_lrck), 16'h0);
      chk("idle_sdin", 16'(bus.audio_sdin), 16'h0);
      chk("idle_fs", 16'(bus.frame_start), 16'h0);
    end else begin
      p = 10'(bc);
      k = p[8:4];
      w = p[9] ? hr : hl;
      e_sd = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
      chk("mclk", 16'(bus.audio_mclk), 16'(p[1]));
      chk("sck", 16'(bus.audio_sck), 16'(p[3]));
      chk("lrck", 16'(bus.audio_lrck), 16'(p[9]));
      chk("fs", 16'(bus.frame_start), 16'(bc == 0));
      chk("sdin", 16'(bus.audio_sdin), 16'(e_sd));
      if (bc == 0) begin
        rx_l = '0;
        rx_r = '0;
      end
      if (p[3:0] == 4'd8 && k >= 1 && k <= 16) begin
        if (p[9]) rx_r = {rx_r[14:0], bus.audio_sdin};
        else      rx_l = {rx_l[14:0], bus.audio_sdin};
      end
      if (bc == 1023) begin
        hl = nl;
        hr = nr;
      end
      bc = (bc + 1) % 1024;
    end
  endtask

  task automatic frame_check(input string tag,
                             input logic [15:0] el,
                             input logic [15:0] er);
    chk({tag, "_l"}, rx_l, el);
    chk({tag, "_r"}, rx_r, er);
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.sample_l = '0;
    bus.sample_r = '0;
    bus.volume   = 3'd0;
    bus.mute     = 1'b0;
    repeat (3) step();

    // basic serial data and clock ratios
    rst = 1'b0;
    bus.en = 1'b1;
    bus.sample_l = 16'hA5C3;
    bus.sample_r = 16'h8001;
    nl = 16'hA5C3;
    nr = 16'h8001;
    repeat (1024) step();
    frame_check("silence", 16'h0000, 16'h0000);

    bus.sample_l = 16'h8000;
    bus.sample_r = 16'h0100;
    bus.volume = 3'd7;
    nl = 16'hFF00;
    nr = 16'h0002;
    repeat (1024) step();
    frame_check("a5c3", 16'hA5C3, 16'h8001);

    bus.sample_l = 16'h7FFF;
    bus.sample_r = 16'h7FFF;
    bus.volume = 3'd3;
    nl = 16'h0FFF;
    nr = 16'h0FFF;
    repeat (1024) step();
    frame_check("vol7", 16'hFF00, 16'h0002);

    bus.mute = 1'b1;
    bus.volume = 3'd0;
    nl = 16'h0000;
    nr = 16'h0000;
    repeat (1024) step();
    frame_check("vol3", 16'h0FFF, 16'h0FFF);

    bus.mute = 1'b0;
    bus.sample_l = 16'h1234;
    bus.sample_r = 16'h00FF;
    nl = 16'h1234;
    nr = 16'h00FF;
    repeat (1024) step();
    frame_check("mute", 16'h0000, 16'h0000);

    // input change mid-frame has no effect now
    repeat (500) step();
    bus.sample_l = 16'h4321;
    nl = 16'h4321;
    repeat (524) step();
    frame_check("hold_keep", 16'h1234, 16'h00FF);
    repeat (1024) step();
    frame_check("hold_new", 16'h4321, 16'h00FF);

    // one-clk reset mid-frame
    repeat (300) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (1024) step();
    frame_check("post_rst", 16'h0000, 16'h0000);
    repeat (1024) step();
    frame_check("after_rst", 16'h4321, 16'h00FF);

    // en drop mid-frame, held words retained
    repeat (700) step();
    bus.en = 1'b0;
    repeat (50) step();
    bus.en = 1'b1;
    step();
    chk("fs_resume", 16'(bus.frame_start), 16'h1);
    repeat (1023) step();
    frame_check("en_resume", 16'h4321, 16'h00FF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Downstream stage of the ROM-backed waveform music player.
- Consumes its 16-bit signed amplitude (plus an optional second channel), applies mute and a shift-based volume, and serialises both channels in I2S format.
- Drives the Pmod I2S2 DAC pins: MCLK, LRCK, SCLK and SDIN.
- Emits a one-cycle frame_start strobe so upstream logic can track the output sample rate.

Parameters:
- CNT_W, 10, frame counter width. One frame is 2^CNT_W clk cycles (1024 cycles = 97.656 kHz at 100 MHz).
- DATA_W, 16, sample width, signed two's complement.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- en  in  1  high = transmit; low = idle (outputs low, counter cleared).
- sample_l  in  DATA_W  left sample, signed; sampled at end of frame.
- sample_r  in  DATA_W  right sample, signed; sampled at end of frame.
- volume  in  3  attenuation; arithmetic right shift by 0..7.
- mute  in  1  high = transmit zeros for both channels.
- audio_mclk  out  1  master clock = clk/4 (25 MHz).
- audio_lrck  out  1  word select: 0 = left half, 1 = right half; clk/1024.
- audio_sck  out  1  serial bit clock = clk/16 (6.25 MHz); 64 SCLK per frame.
- audio_sdin  out  1  serial data, changes on SCLK falling edge.
- frame_start  out  1  one-clk pulse at the first cycle of each frame.

Behaviour:
- Frame counter cnt[CNT_W-1:0]:
  - rst, or en = 0: cnt <= 0 next cycle.
  - Otherwise cnt <= cnt+1, wrapping 1023 -> 0.
- All pin outputs are registered, one-clk latency from the cnt value they decode:
  - audio_mclk = cnt[1]
  - audio_sck = cnt[3]
  - audio_lrck = cnt[9]
  - All three are forced 0 when en = 0 or rst.
- Channel slot index k = cnt[8:4] (0..31) within each half-frame.
- audio_sdin for slot k:
  - k = 1..16: bit (16-k) of the channel's held word, so the MSB goes out in slot 1, one SCLK after the LRCK edge (I2S).
  - k = 0 and k = 17..31: 0.
  - Changes only when cnt[3:0] wraps 15 -> 0, i.e. coincident with an SCLK falling edge.
- Sample processing (combinational, signed):
  - proc_x = mute ? 0 : (sample_x >>> volume).
  - Sign is preserved. Examples: -32768 >>> 7 = -256; -1 >>> any = -1.
- Capture:
  - When en = 1 and cnt == 1023, hold_l <= proc_l and hold_r <= proc_r.
  - The new words go out in the frame starting next cycle.
  - Inputs change at other times and have no effect on the current frame.
- Left half (lrck = 0) serialises hold_l; right half serialises hold_r.
- frame_start = 1 for exactly one clk, registered, in the cycle where cnt == 0 while en = 1. It is never asserted while en = 0.
- Reset values: every output 0, cnt = 0, hold_l = hold_r = 0.
- Reset mid-frame: the frame is aborted; on release transmission restarts at cnt = 0 with hold words = 0.
  - The first frame after reset therefore transmits silence.
  - The first real sample appears in the second frame.
- en falling mid-frame: same as reset, except hold words are retained. On en rising, cnt starts at 0 and the held words are retransmitted.
- Simultaneous mute/volume change at cnt == 1023: the values present in that cycle are used.
- No back-pressure; upstream must present valid samples continuously.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_DATA_W = 16
  - FRAME_CNT_W = 10
  - slot bounds: MSB_SLOT = 1, LSB_SLOT = 16
  - divider bit positions: MCLK_BIT = 1, SCK_BIT = 3, LRCK_BIT = 9
- One natural sub-module, audio_vol_scale: combinational mute/shift stage, instantiated twice (L, R).
- Counter, capture registers and serialiser stay in the top module.

Test Plan:
- Clock ratios: rst, then en = 1 for 3 frames -> mclk period 4 clk, sck period 16 clk, lrck period 1024 clk with 512 low / 512 high, frame_start every 1024 clk.
- Serial data: sample_l = 16'hA5C3, sample_r = 16'h8001, volume = 0 -> frame 2 left slots 1..16 = 1010010111000011 MSB-first, right slots 1..16 = 1000000000000001, all other slots 0, sdin stable across every SCLK rising edge.
- Volume and mute:
  - sample_l = -32768, volume = 7 -> left word 16'hFF00.
  - sample_l = 16'h7FFF, volume = 3 -> 16'h0FFF.
  - mute = 1 -> both words 0.
- Capture timing: change sample_l from 16'h1234 to 16'h4321 at cnt = 500 -> current frame still sends 16'h1234; the next frame sends 16'h4321.
- Mid-frame reset: assert rst at cnt = 300 for 1 clk -> all outputs 0 next cycle, cnt restarts at 0, first frame sends zeros, frame_start 1024 clk later.
- en toggle: drop en at cnt = 700 -> outputs low, no frame_start. Raise en 50 clk later -> frame_start in the cycle after cnt = 0, held words retransmitted.
